// File: rtl/map_table_pkg.sv
// Shared types and constants for the 2-wide rename map table.
// The map table and the architectural map table both import it.
package map_table_pkg;

  localparam int unsigned ARCH_REG_NUM = 32;
  localparam int unsigned PHY_REG_NUM  = 64;
  localparam int unsigned DP_NUM       = 2;
  localparam int unsigned CDB_NUM      = 2;
  localparam int unsigned RT_NUM       = 2;
  localparam int unsigned AR_IDX       = $clog2(ARCH_REG_NUM);
  localparam int unsigned PR_IDX       = $clog2(PHY_REG_NUM);

  typedef logic [AR_IDX-1:0] areg_t;
  typedef logic [PR_IDX-1:0] ptag_t;

  localparam areg_t ZERO_REG  = '0;
  localparam ptag_t ZERO_PREG = '0;

  typedef struct packed {
    logic  valid;
    areg_t rd;
    areg_t rs1;
    areg_t rs2;
  } DP_MT;

  typedef struct packed {
    ptag_t rs1_tag;
    ptag_t rs2_tag;
    logic  rs1_ready;
    logic  rs2_ready;
    ptag_t told;
  } MT_DP;

  typedef struct packed {
    logic  valid;
    ptag_t tag;
  } CDB;

  typedef struct packed {
    logic  valid;
    areg_t rd;
    ptag_t tag;
  } ROB_AMT;

  typedef CDB [CDB_NUM-1:0]       cdb_vec_t;
  typedef ptag_t [ARCH_REG_NUM-1:0] map_t;

  function automatic logic cdb_hit(input ptag_t tag, input cdb_vec_t cdb);
    cdb_hit = 1'b0;
    for (int unsigned c = 0; c < CDB_NUM; c++) begin
      if (cdb[c].valid && (cdb[c].tag == tag)) cdb_hit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/map_table_if.sv
// Dispatch, CDB and retire signals of the rename map table.
// The slave modport is the map table's view.
interface map_table_if;
  import map_table_pkg::*;

  logic [DP_NUM-1:0]             dp_valid_i;
  logic [DP_NUM-1:0][AR_IDX-1:0] dp_rd_i;
  logic [DP_NUM-1:0][AR_IDX-1:0] dp_rs1_i;
  logic [DP_NUM-1:0][AR_IDX-1:0] dp_rs2_i;
  logic [DP_NUM-1:0][PR_IDX-1:0] fl_tag_i;
  logic [DP_NUM-1:0][PR_IDX-1:0] rs1_tag_o;
  logic [DP_NUM-1:0][PR_IDX-1:0] rs2_tag_o;
  logic [DP_NUM-1:0]             rs1_ready_o;
  logic [DP_NUM-1:0]             rs2_ready_o;
  logic [DP_NUM-1:0][PR_IDX-1:0] told_o;
  logic [CDB_NUM-1:0]             cdb_valid_i;
  logic [CDB_NUM-1:0][PR_IDX-1:0] cdb_tag_i;
  logic [RT_NUM-1:0]             rt_valid_i;
  logic [RT_NUM-1:0][AR_IDX-1:0] rt_rd_i;
  logic [RT_NUM-1:0][PR_IDX-1:0] rt_tag_i;

  modport slave (
    input  dp_valid_i, dp_rd_i, dp_rs1_i, dp_rs2_i, fl_tag_i,
    input  cdb_valid_i, cdb_tag_i, rt_valid_i, rt_rd_i, rt_tag_i,
    output rs1_tag_o, rs2_tag_o, rs1_ready_o, rs2_ready_o, told_o
  );

  modport master (
    output dp_valid_i, dp_rd_i, dp_rs1_i, dp_rs2_i, fl_tag_i,
    output cdb_valid_i, cdb_tag_i, rt_valid_i, rt_rd_i, rt_tag_i,
    input  rs1_tag_o, rs2_tag_o, rs1_ready_o, rs2_ready_o, told_o
  );

endinterface

// File: rtl/map_table_amt.sv
// Architectural map table: committed mappings updated at retire.
// amt_next is exported so rollback can restore from it in the same cycle.
module arch_map_table
  import map_table_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  ROB_AMT [RT_NUM-1:0]  rt,
  output map_t                 amt_next
);

  map_t amt;

  always_comb begin
    amt_next = amt;
    for (int unsigned s = 0; s < RT_NUM; s++) begin
      if (rt[s].valid && (rt[s].rd != ZERO_REG)) amt_next[rt[s].rd] = rt[s].tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REG_NUM; i++) amt[i] <= ptag_t'(i);
    end else begin
      amt <= amt_next;
    end
  end

endmodule

// File: rtl/map_table.sv
// 2-wide speculative rename map with ready bits, CDB wakeup and
// rollback restore from the architectural map.
module map_table
  import map_table_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rollback_i,
  map_table_if.slave  bus
);

  DP_MT   [DP_NUM-1:0] dp;
  MT_DP   [DP_NUM-1:0] res;
  cdb_vec_t            cdb;
  ROB_AMT [RT_NUM-1:0] rt;

  map_t                    mt, mt_next, amt_next;
  logic [ARCH_REG_NUM-1:0] rdy, rdy_next;

  always_comb begin
    dp  = '0;
    cdb = '0;
    rt  = '0;
    for (int unsigned s = 0; s < DP_NUM; s++) begin
      dp[s].valid = bus.dp_valid_i[s];
      dp[s].rd    = bus.dp_rd_i[s];
      dp[s].rs1   = bus.dp_rs1_i[s];
      dp[s].rs2   = bus.dp_rs2_i[s];
    end
    for (int unsigned c = 0; c < CDB_NUM; c++) begin
      cdb[c].valid = bus.cdb_valid_i[c];
      cdb[c].tag   = bus.cdb_tag_i[c];
    end
    for (int unsigned r = 0; r < RT_NUM; r++) begin
      rt[r].valid = bus.rt_valid_i[r];
      rt[r].rd    = bus.rt_rd_i[r];
      rt[r].tag   = bus.rt_tag_i[r];
    end
  end

  arch_map_table u_amt (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .rt       (rt),
    .amt_next (amt_next)
  );

  // Older slots in the group override the MT view; the youngest matching
  // older writer wins, and x0 is forced last so it can never be forwarded.
  always_comb begin
    res = '0;
    for (int unsigned s = 0; s < DP_NUM; s++) begin
      if (dp[s].valid) begin
        res[s].rs1_tag   = mt[dp[s].rs1];
        res[s].rs1_ready = rdy[dp[s].rs1] | cdb_hit(mt[dp[s].rs1], cdb);
        res[s].rs2_tag   = mt[dp[s].rs2];
        res[s].rs2_ready = rdy[dp[s].rs2] | cdb_hit(mt[dp[s].rs2], cdb);
        res[s].told      = (dp[s].rd == ZERO_REG) ? ZERO_PREG : mt[dp[s].rd];
        for (int unsigned p = 0; p < s; p++) begin
          if (dp[p].valid && (dp[p].rd != ZERO_REG)) begin
            if (dp[s].rs1 == dp[p].rd) begin
              res[s].rs1_tag   = bus.fl_tag_i[p];
              res[s].rs1_ready = 1'b0;
            end
            if (dp[s].rs2 == dp[p].rd) begin
              res[s].rs2_tag   = bus.fl_tag_i[p];
              res[s].rs2_ready = 1'b0;
            end
            if (dp[s].rd == dp[p].rd) res[s].told = bus.fl_tag_i[p];
          end
        end
        if (dp[s].rs1 == ZERO_REG) begin
          res[s].rs1_tag   = ZERO_PREG;
          res[s].rs1_ready = 1'b1;
        end
        if (dp[s].rs2 == ZERO_REG) begin
          res[s].rs2_tag   = ZERO_PREG;
          res[s].rs2_ready = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.rs1_tag_o   = '0;
    bus.rs2_tag_o   = '0;
    bus.rs1_ready_o = '0;
    bus.rs2_ready_o = '0;
    bus.told_o      = '0;
    for (int unsigned s = 0; s < DP_NUM; s++) begin
      bus.rs1_tag_o[s]   = res[s].rs1_tag;
      bus.rs2_tag_o[s]   = res[s].rs2_tag;
      bus.rs1_ready_o[s] = res[s].rs1_ready;
      bus.rs2_ready_o[s] = res[s].rs2_ready;
      bus.told_o[s]      = res[s].told;
    end
  end

  // CDB wakeup first, then dispatch writes so a same-cycle rename clears ready.
  always_comb begin
    mt_next  = mt;
    rdy_next = rdy;
    if (rollback_i) begin
      mt_next  = amt_next;
      rdy_next = '1;
    end else begin
      for (int unsigned i = 0; i < ARCH_REG_NUM; i++) begin
        if (cdb_hit(mt[i], cdb)) rdy_next[i] = 1'b1;
      end
      for (int unsigned s = 0; s < DP_NUM; s++) begin
        if (dp[s].valid && (dp[s].rd != ZERO_REG)) begin
          mt_next[dp[s].rd]  = bus.fl_tag_i[s];
          rdy_next[dp[s].rd] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < ARCH_REG_NUM; i++) mt[i] <= ptag_t'(i);
      rdy <= '1;
    end else begin
      mt  <= mt_next;
      rdy <= rdy_next;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Randomized self-checking bench for map_table against a behavioural
// rename model (sequential per-slot view of the map).
module tb_map_table;
  import map_table_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rollback = 1'b0;

  always #5 clk = ~clk;

  map_table_if bus();

  map_table dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .rollback_i (rollback),
    .bus        (bus.slave)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int mt_m[32];
  bit rdy_m[32];
  int amt_m[32];
  int nmt[32];
  bit nrdy[32];
  int namt[32];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mt_m[i] = i;
      rdy_m[i] = 1'b1;
      amt_m[i] = i;
    end
  endtask

  task automatic drive_idle();
    rollback = 1'b0;
    bus.dp_valid_i  = '0;
    bus.dp_rd_i     = '0;
    bus.dp_rs1_i    = '0;
    bus.dp_rs2_i    = '0;
    bus.fl_tag_i    = '0;
    bus.cdb_valid_i = '0;
    bus.cdb_tag_i   = '0;
    bus.rt_valid_i  = '0;
    bus.rt_rd_i     = '0;
    bus.rt_tag_i    = '0;
  endtask

  task automatic set_slot(input int s, input bit v, input int rd, input int rs1,
                          input int rs2, input int fl);
    bus.dp_valid_i[s] = v;
    bus.dp_rd_i[s]    = 5'(rd);
    bus.dp_rs1_i[s]   = 5'(rs1);
    bus.dp_rs2_i[s]   = 5'(rs2);
    bus.fl_tag_i[s]   = 6'(fl);
  endtask

  function automatic bit cdb_has(input int t);
    bit hit = 1'b0;
    for (int c = 0; c < CDB_NUM; c++)
      if (bus.cdb_valid_i[c] && (int'(bus.cdb_tag_i[c]) == t)) hit = 1'b1;
    return hit;
  endfunction

  // Slots rename in order against a running view; the view after all slots
  // (with CDB wakeups folded in) is the next speculative map.
  task automatic eval_model();
    int view[32];
    bit vrdy[32];
    int rd, rs1, rs2, e1, e2, eo;
    bit r1, r2;
    for (int i = 0; i < 32; i++) begin
      view[i] = mt_m[i];
      vrdy[i] = rdy_m[i] | cdb_has(mt_m[i]);
    end
    for (int s = 0; s < DP_NUM; s++) begin
      rd = int'(bus.dp_rd_i[s]);
      rs1 = int'(bus.dp_rs1_i[s]);
      rs2 = int'(bus.dp_rs2_i[s]);
      e1 = 0; e2 = 0; eo = 0; r1 = 0; r2 = 0;
      if (bus.dp_valid_i[s]) begin
        e1 = (rs1 == 0) ? 0 : view[rs1];
        r1 = (rs1 == 0) ? 1'b1 : vrdy[rs1];
        e2 = (rs2 == 0) ? 0 : view[rs2];
        r2 = (rs2 == 0) ? 1'b1 : vrdy[rs2];
        eo = (rd == 0) ? 0 : view[rd];
        if (rd != 0) begin
          view[rd] = int'(bus.fl_tag_i[s]);
          vrdy[rd] = 1'b0;
        end
      end
      check($sformatf("s%0d_rs1_tag", s), 32'(bus.rs1_tag_o[s]), 32'(e1));
      check($sformatf("s%0d_rs1_rdy", s), 32'(bus.rs1_ready_o[s]), 32'(r1));
      check($sformatf("s%0d_rs2_tag", s), 32'(bus.rs2_tag_o[s]), 32'(e2));
      check($sformatf("s%0d_rs2_rdy", s), 32'(bus.rs2_ready_o[s]), 32'(r2));
      check($sformatf("s%0d_told", s), 32'(bus.told_o[s]), 32'(eo));
    end
    for (int i = 0; i < 32; i++) namt[i] = amt_m[i];
    for (int r = 0; r < RT_NUM; r++)
      if (bus.rt_valid_i[r] && (bus.rt_rd_i[r] != 0)) namt[bus.rt_rd_i[r]] = int'(bus.rt_tag_i[r]);
    for (int i = 0; i < 32; i++) begin
      nmt[i]  = rollback ? namt[i] : view[i];
      nrdy[i] = rollback ? 1'b1 : vrdy[i];
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    eval_model();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      mt_m[i] = nmt[i];
      rdy_m[i] = nrdy[i];
      amt_m[i] = namt[i];
    end
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
  endfunction

  task automatic rand_inputs();
    int f0, f1, t;
    drive_idle();
    rollback = ($urandom_range(0, 15) == 0);
    f0 = int'($urandom_range(32, 63));
    do f1 = int'($urandom_range(32, 63)); while (f1 == f0);
    set_slot(0, $urandom_range(0, 3) != 0, pick_reg(), pick_reg(), pick_reg(), f0);
    set_slot(1, $urandom_range(0, 3) != 0, pick_reg(), pick_reg(), pick_reg(), f1);
    for (int c = 0; c < CDB_NUM; c++) begin
      t = ($urandom_range(0, 3) != 0) ? mt_m[$urandom_range(0, 31)] : int'($urandom_range(0, 63));
      bus.cdb_valid_i[c] = ($urandom_range(0, 1) == 1) && (t != f0) && (t != f1);
      bus.cdb_tag_i[c]   = 6'(t);
    end
    for (int r = 0; r < RT_NUM; r++) begin
      bus.rt_valid_i[r] = ($urandom_range(0, 1) == 1);
      bus.rt_rd_i[r]    = 5'(pick_reg());
      bus.rt_tag_i[r]   = 6'($urandom_range(0, 63));
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state: identity mapping, all ready
    for (int r = 0; r < 32; r++) begin
      set_slot(0, 1'b1, 0, r, 31 - r, 0);
      #1;
      check("rst_tag", 32'(bus.rs1_tag_o[0]), 32'(r));
      check("rst_rdy", 32'(bus.rs1_ready_o[0]), 32'd1);
    end
    drive_idle();
    @(posedge clk);
    #1;

    // Basic rename of x5
    set_slot(0, 1'b1, 5, 5, 0, 32);
    #1;
    check("t1_rs1_tag", 32'(bus.rs1_tag_o[0]), 32'd5);
    check("t1_rs1_rdy", 32'(bus.rs1_ready_o[0]), 32'd1);
    check("t1_told", 32'(bus.told_o[0]), 32'd5);
    run_cycle();
    drive_idle();
    set_slot(0, 1'b1, 0, 5, 0, 0);
    #1;
    check("t1_next_tag", 32'(bus.rs1_tag_o[0]), 32'd32);
    check("t1_next_rdy", 32'(bus.rs1_ready_o[0]), 32'd0);
    run_cycle();

    // Intra-group forwarding and same-rd ordering
    drive_idle();
    set_slot(0, 1'b1, 3, 0, 0, 40);
    set_slot(1, 1'b1, 3, 3, 0, 41);
    #1;
    check("t2_s1_tag", 32'(bus.rs1_tag_o[1]), 32'd40);
    check("t2_s1_rdy", 32'(bus.rs1_ready_o[1]), 32'd0);
    check("t2_told1", 32'(bus.told_o[1]), 32'd40);
    check("t2_told0", 32'(bus.told_o[0]), 32'd3);
    run_cycle();
    drive_idle();
    set_slot(0, 1'b1, 0, 3, 0, 0);
    #1;
    check("t2_mt3", 32'(bus.rs1_tag_o[0]), 32'd41);

    // CDB bypass on lookup, then wakeup in MT
    bus.cdb_valid_i[0] = 1'b1;
    bus.cdb_tag_i[0] = 6'd41;
    #1;
    check("t3_bypass", 32'(bus.rs1_ready_o[0]), 32'd1);
    run_cycle();
    drive_idle();
    set_slot(0, 1'b1, 0, 3, 0, 0);
    #1;
    check("t3_woken", 32'(bus.rs1_ready_o[0]), 32'd1);
    run_cycle();

    // Dispatch beats CDB on the same entry
    drive_idle();
    set_slot(0, 1'b1, 7, 0, 0, 50);
    bus.cdb_valid_i[1] = 1'b1;
    bus.cdb_tag_i[1] = 6'd50;
    run_cycle();
    drive_idle();
    set_slot(0, 1'b1, 0, 7, 0, 0);
    #1;
    check("t4_tag", 32'(bus.rs1_tag_o[0]), 32'd50);
    check("t4_rdy", 32'(bus.rs1_ready_o[0]), 32'd0);
    run_cycle();

    // Rollback with a same-cycle retire
    drive_idle();
    set_slot(0, 1'b1, 9, 0, 0, 45);
    run_cycle();
    drive_idle();
    rollback = 1'b1;
    bus.rt_valid_i[0] = 1'b1;
    bus.rt_rd_i[0] = 5'd5;
    bus.rt_tag_i[0] = 6'd32;
    set_slot(0, 1'b1, 12, 0, 0, 55);
    run_cycle();
    drive_idle();
    set_slot(0, 1'b1, 0, 5, 9, 0);
    set_slot(1, 1'b1, 0, 3, 12, 0);
    #1;
    check("t5_x5", 32'(bus.rs1_tag_o[0]), 32'd32);
    check("t5_x5_rdy", 32'(bus.rs1_ready_o[0]), 32'd1);
    check("t5_x9", 32'(bus.rs2_tag_o[0]), 32'd9);
    check("t5_x9_rdy", 32'(bus.rs2_ready_o[0]), 32'd1);
    check("t5_x3", 32'(bus.rs1_tag_o[1]), 32'd3);
    check("t5_x12", 32'(bus.rs2_tag_o[1]), 32'd12);
    run_cycle();

    // x0 destination and source
    drive_idle();
    set_slot(0, 1'b1, 0, 0, 0, 60);
    set_slot(1, 1'b1, 0, 0, 0, 61);
    #1;
    check("t6_told", 32'(bus.told_o[0]), 32'd0);
    check("t6_rs1", 32'(bus.rs1_tag_o[0]), 32'd0);
    check("t6_rdy", 32'(bus.rs1_ready_o[0]), 32'd1);
    check("t6_s1_rs1", 32'(bus.rs1_tag_o[1]), 32'd0);
    run_cycle();

    // Invalid slot drives zeros
    drive_idle();
    set_slot(1, 1'b0, 5, 5, 7, 33);
    #1;
    check("inv_told", 32'(bus.told_o[1]), 32'd0);
    check("inv_tag", 32'(bus.rs1_tag_o[1]), 32'd0);
    run_cycle();

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      run_cycle();
    end

    // Asynchronous reset in the middle of traffic
    rand_inputs();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      check("arst_mt", 32'(dut.mt[i]), 32'(i));
      check("arst_amt", 32'(dut.u_amt.amt[i]), 32'(i));
      check("arst_rdy", 32'(dut.rdy[i]), 32'd1);
    end
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 100; n++) begin
      rand_inputs();
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
